// File: rtl/i2c_pcf8574_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_pcf8574_target
//  Description : I2C target emulating a PCF8574 8-bit I/O expander. Addressed
//                writes update port_out, addressed reads return a snapshot of
//                port_in. Runs on clk_1MHz with scl/sda oversampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_pcf8574_target #(
    parameter logic [6:0] ADDR = 7'h27
) (
    input  logic       clk_1MHz,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] port_in,
    output logic [7:0] port_out,
    output logic       byte_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_WR_DATA  = 3'd3,
        S_WR_ACK   = 3'd4,
        S_RD_DATA  = 3'd5,
        S_RD_ACK   = 3'd6,
        S_IGNORE   = 3'd7
    } state_t;

    localparam logic [2:0] c_last_bit = 3'd7;

    // Synchronizer and history flops (reset to idle-bus level to avoid false edges)
    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    // Registered FSM state and datapath
    state_t     r_state, state_n;
    logic [2:0] r_cnt, cnt_n;
    logic [7:0] r_shift, shift_n;
    logic       r_full, full_n;     // complete byte received, waiting for SCL fall
    logic       r_rw, rw_n;         // R/W bit of the address byte
    logic       r_ack, ack_n;       // initiator ACKed the last read byte
    logic       r_drive, drive_n;   // request to pull sda low
    logic       r_busy, busy_n;
    logic       r_load, load_n;     // write byte complete, update port_out next cycle
    logic       r_sda_low;          // open-drain output register

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_shift_in;

    // Two-flop synchronizers plus one history flop per bus line
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & ~r_sda_d & r_sda_s2;
    assign w_shift_in = {r_shift[6:0], r_sda_s2};

    // FSM state and datapath registers
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_shift <= 8'h00;
            r_full  <= 1'b0;
            r_rw    <= 1'b0;
            r_ack   <= 1'b0;
            r_drive <= 1'b0;
            r_busy  <= 1'b0;
            r_load  <= 1'b0;
        end else begin
            r_state <= state_n;
            r_cnt   <= cnt_n;
            r_shift <= shift_n;
            r_full  <= full_n;
            r_rw    <= rw_n;
            r_ack   <= ack_n;
            r_drive <= drive_n;
            r_busy  <= busy_n;
            r_load  <= load_n;
        end
    end

    // Next-state logic; START/STOP override any SCL strobe in the same cycle
    always_comb begin
        state_n = r_state;
        cnt_n   = r_cnt;
        shift_n = r_shift;
        full_n  = r_full;
        rw_n    = r_rw;
        ack_n   = r_ack;
        drive_n = r_drive;
        busy_n  = r_busy;
        load_n  = 1'b0;

        if (w_start) begin
            state_n = S_ADDR;
            cnt_n   = 3'd0;
            full_n  = 1'b0;
            ack_n   = 1'b0;
            drive_n = 1'b0;
            busy_n  = 1'b1;
        end else if (w_stop) begin
            state_n = S_IDLE;
            cnt_n   = 3'd0;
            full_n  = 1'b0;
            ack_n   = 1'b0;
            drive_n = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_IGNORE: begin
                    drive_n = 1'b0;
                end
                S_ADDR: begin
                    if (w_scl_rise && !r_full) begin
                        shift_n = w_shift_in;
                        cnt_n   = r_cnt + 3'd1;
                        if (r_cnt == c_last_bit) begin
                            if (w_shift_in[7:1] == ADDR) full_n  = 1'b1;
                            else                         state_n = S_IGNORE;
                        end
                    end else if (w_scl_fall && r_full) begin
                        full_n  = 1'b0;
                        rw_n    = r_shift[0];
                        drive_n = 1'b1;
                        state_n = S_ADDR_ACK;
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        cnt_n = 3'd0;
                        if (!r_rw) begin
                            drive_n = 1'b0;
                            state_n = S_WR_DATA;
                        end else begin
                            shift_n = port_in;
                            drive_n = ~port_in[7];
                            state_n = S_RD_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_scl_rise && !r_full) begin
                        shift_n = w_shift_in;
                        cnt_n   = r_cnt + 3'd1;
                        if (r_cnt == c_last_bit) begin
                            full_n = 1'b1;
                            load_n = 1'b1;
                        end
                    end else if (w_scl_fall && r_full) begin
                        full_n  = 1'b0;
                        drive_n = 1'b1;
                        state_n = S_WR_ACK;
                    end
                end
                S_WR_ACK: begin
                    if (w_scl_fall) begin
                        cnt_n   = 3'd0;
                        drive_n = 1'b0;
                        state_n = S_WR_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (w_scl_fall) begin
                        if (r_cnt == c_last_bit) begin
                            cnt_n   = 3'd0;
                            ack_n   = 1'b0;
                            drive_n = 1'b0;
                            state_n = S_RD_ACK;
                        end else begin
                            cnt_n   = r_cnt + 3'd1;
                            shift_n = {r_shift[6:0], 1'b0};
                            drive_n = ~r_shift[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (w_scl_rise) begin
                        if (!r_sda_s2) ack_n   = 1'b1;
                        else           state_n = S_IGNORE;
                    end else if (w_scl_fall && r_ack) begin
                        ack_n   = 1'b0;
                        cnt_n   = 3'd0;
                        shift_n = port_in;
                        drive_n = ~port_in[7];
                        state_n = S_RD_DATA;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    drive_n = 1'b0;
                end
            endcase
        end
    end

    // Output registers: sda pull-down, written byte and its strobe
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_sda_low  <= 1'b0;
            port_out   <= 8'hFF;
            byte_valid <= 1'b0;
        end else begin
            r_sda_low  <= r_drive;
            byte_valid <= r_load;
            if (r_load) port_out <= r_shift;
        end
    end

    assign busy = r_busy;
    assign sda  = r_sda_low ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_i2c_pcf8574_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_pcf8574_target
//  Description : Self-checking bench for i2c_pcf8574_target; bit-banged
//                initiator with write/read scoreboards.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_pcf8574_target;

    localparam int H = 10;   // SCL half period in clk_1MHz cycles

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       m_low;
    logic [7:0] port_in;
    wire        sda;
    logic [7:0] port_out;
    logic       byte_valid;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;
    int dut_low_cnt = 0;
    logic [7:0] wr_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] mon_exp;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_pcf8574_target #(.ADDR(7'h27)) dut (
        .clk_1MHz  (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda       (sda),
        .port_in   (port_in),
        .port_out  (port_out),
        .byte_valid(byte_valid),
        .busy      (busy)
    );

    always #500 clk = ~clk;

    // Write scoreboard: each byte_valid pulse pops the expected byte
    always @(negedge clk) begin
        if (rst_n && byte_valid) begin
            pulse_cnt++;
            checks++;
            if (wr_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected: port_out=%h, expected no pulse", port_out);
            end else begin
                mon_exp = wr_q.pop_front();
                if (port_out !== mon_exp) begin
                    failures++;
                    $display("FAIL wr_byte: port_out=%h expected %h", port_out, mon_exp);
                end
            end
        end
        if (rst_n && !m_low && sda === 1'b0) dut_low_cnt++;
    end

    initial begin
        #(50_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start;
        wait_clk(2); m_low = 1'b0;
        wait_clk(H); scl = 1'b1;
        wait_clk(H); m_low = 1'b1;
        wait_clk(H); scl = 1'b0;
    endtask

    task automatic i2c_stop;
        wait_clk(2); m_low = 1'b1;
        wait_clk(H); scl = 1'b1;
        wait_clk(H); m_low = 1'b0;
        wait_clk(H);
    endtask

    task automatic write_bit(input logic b);
        wait_clk(2); m_low = ~b;
        wait_clk(H - 2); scl = 1'b1;
        wait_clk(H); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        wait_clk(2); m_low = 1'b0;
        wait_clk(H - 2); scl = 1'b1;
        wait_clk(H / 2); @(negedge clk);
        acked = (sda === 1'b0);
        wait_clk(H / 2); scl = 1'b0;
    endtask

    task automatic read_byte(input logic ack_it, output logic [7:0] d, output logic released);
        m_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            wait_clk(H); scl = 1'b1;
            wait_clk(H / 2); @(negedge clk);
            d[i] = (sda !== 1'b0);
            wait_clk(H / 2); scl = 1'b0;
        end
        wait_clk(2); m_low = ack_it;
        wait_clk(H - 2); scl = 1'b1;
        wait_clk(H / 2); @(negedge clk);
        released = (sda === 1'b1);
        wait_clk(H / 2); scl = 1'b0;
        wait_clk(2); m_low = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; scl = 1'b1; m_low = 1'b0; port_in = 8'h00;
        wait_clk(3); @(negedge clk);
        checks++; if (port_out !== 8'hFF) begin failures++; $display("FAIL reset_port_out: got %h expected ff", port_out); end
        checks++; if (byte_valid !== 1'b0) begin failures++; $display("FAIL reset_byte_valid: got %b expected 0", byte_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (sda !== 1'b1) begin failures++; $display("FAIL reset_sda: got %b expected released(1)", sda); end
        @(posedge clk); rst_n = 1'b1;
        wait_clk(5);
    endtask

    task automatic test_mismatch;
        logic ack;
        int base;
        base = pulse_cnt;
        dut_low_cnt = 0;
        i2c_start();
        write_byte(8'h40, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL mismatch_addr_ack: got %b expected 0", ack); end
        write_byte(8'h12, ack);
        i2c_stop();
        wait_clk(5);
        checks++; if (dut_low_cnt != 0) begin failures++; $display("FAIL mismatch_sda_driven: got %0d low cycles expected 0", dut_low_cnt); end
        checks++; if (port_out !== 8'hFF) begin failures++; $display("FAIL mismatch_port_out: got %h expected ff", port_out); end
        checks++; if (pulse_cnt - base != 0) begin failures++; $display("FAIL mismatch_pulses: got %0d expected 0", pulse_cnt - base); end
    endtask

    task automatic test_write;
        logic ack;
        int base;
        base = pulse_cnt;
        i2c_start();
        wait_clk(2); @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy_start: got %b expected 1", busy); end
        write_byte(8'h4E, ack);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL write_addr_ack: got %b expected 1", ack); end
        wr_q.push_back(8'h5C);
        write_byte(8'h5C, ack);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL write_data_ack: got %b expected 1", ack); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy_mid: got %b expected 1", busy); end
        i2c_stop();
        wait_clk(5); @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_stop: got %b expected 0", busy); end
        checks++; if (port_out !== 8'h5C) begin failures++; $display("FAIL write_port_out: got %h expected 5c", port_out); end
        checks++; if (pulse_cnt - base != 1) begin failures++; $display("FAIL write_pulses: got %0d expected 1", pulse_cnt - base); end
    endtask

    task automatic test_read;
        logic ack, rel;
        logic [7:0] d, e;
        port_in = 8'hA5;
        rd_q.push_back(8'hA5);
        i2c_start();
        write_byte(8'h4F, ack);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL read_addr_ack: got %b expected 1", ack); end
        read_byte(1'b0, d, rel);
        i2c_stop();
        e = rd_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL read_data: got %h expected %h", d, e); end
        checks++; if (rel !== 1'b1) begin failures++; $display("FAIL read_nack_released: got %b expected 1", rel); end
    endtask

    task automatic test_multi_write;
        logic ack;
        int base;
        logic [7:0] vals [3];
        vals = '{8'h11, 8'h22, 8'h33};
        base = pulse_cnt;
        i2c_start();
        write_byte(8'h4E, ack);
        for (int i = 0; i < 3; i++) begin
            wr_q.push_back(vals[i]);
            write_byte(vals[i], ack);
            checks++; if (ack !== 1'b1) begin failures++; $display("FAIL multi_wr_ack%0d: got %b expected 1", i, ack); end
        end
        i2c_stop();
        wait_clk(5);
        checks++; if (pulse_cnt - base != 3) begin failures++; $display("FAIL multi_wr_pulses: got %0d expected 3", pulse_cnt - base); end
        checks++; if (port_out !== 8'h33) begin failures++; $display("FAIL multi_wr_port_out: got %h expected 33", port_out); end
        checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL multi_wr_queue: got %0d left expected 0", wr_q.size()); end
    endtask

    task automatic test_multi_read;
        logic ack, rel;
        logic [7:0] d, e;
        port_in = 8'h96;
        rd_q.push_back(8'h96);
        i2c_start();
        write_byte(8'h4F, ack);
        wait_clk(6);
        port_in = 8'h3C;
        rd_q.push_back(8'h3C);
        read_byte(1'b1, d, rel);
        e = rd_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL multi_rd_first: got %h expected %h", d, e); end
        read_byte(1'b0, d, rel);
        e = rd_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL multi_rd_second: got %h expected %h", d, e); end
        i2c_stop();
    endtask

    task automatic test_repeated_start;
        logic ack;
        int base;
        base = pulse_cnt;
        i2c_start();
        write_byte(8'h4E, ack);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_start();
        write_byte(8'h4E, ack);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL rstart_addr_ack: got %b expected 1", ack); end
        wr_q.push_back(8'h77);
        write_byte(8'h77, ack);
        i2c_stop();
        wait_clk(5);
        checks++; if (pulse_cnt - base != 1) begin failures++; $display("FAIL rstart_pulses: got %0d expected 1", pulse_cnt - base); end
        checks++; if (port_out !== 8'h77) begin failures++; $display("FAIL rstart_port_out: got %h expected 77", port_out); end
    endtask

    task automatic test_reset_mid_read;
        logic ack;
        port_in = 8'h00;
        i2c_start();
        write_byte(8'h4F, ack);
        wait_clk(6); @(negedge clk);
        checks++; if (sda !== 1'b0) begin failures++; $display("FAIL rst_mid_driving: got %b expected 0", sda); end
        #100 rst_n = 1'b0;
        #50;
        checks++; if (sda !== 1'b1) begin failures++; $display("FAIL rst_mid_sda_async: got %b expected released(1)", sda); end
        checks++; if (port_out !== 8'hFF) begin failures++; $display("FAIL rst_mid_port_out: got %h expected ff", port_out); end
        checks++; if (busy !== 1'b0 || byte_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_flags: got busy=%b bv=%b expected 0/0", busy, byte_valid); end
        scl = 1'b1; m_low = 1'b0;
        wait_clk(3); rst_n = 1'b1;
        wait_clk(5);
        i2c_start();
        write_byte(8'h4E, ack);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL rst_mid_after_ack: got %b expected 1", ack); end
        wr_q.push_back(8'hC3);
        write_byte(8'hC3, ack);
        i2c_stop();
        wait_clk(5);
        checks++; if (port_out !== 8'hC3) begin failures++; $display("FAIL rst_mid_after_write: got %h expected c3", port_out); end
    endtask

    initial begin
        test_reset();
        test_mismatch();
        test_write();
        test_read();
        test_multi_write();
        test_multi_read();
        test_repeated_start();
        test_reset_mid_read();
        wait_clk(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
